// File: rtl/haar_idwt_serializer_pkg.sv
// Shared constants and state encoding for the inverse Haar serializer.
package haar_idwt_serializer_pkg;

    localparam int unsigned COEF_W    = 16;
    localparam int unsigned HAAR_K    = 181;
    localparam int unsigned HAAR_FRAC = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        EMIT0   = 2'd2,
        EMIT1   = 2'd3
    } state_t;

endpackage

// File: rtl/brent_kung_adder_32bit.sv
// 32-bit Brent-Kung prefix adder, carry-in 0, result modulo 2^32.
module brent_kung_adder_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    always_comb begin
        logic [31:0] g;
        logic [31:0] pg;
        logic [4:0]  ii;
        logic [4:0]  jj;
        g  = i_a & i_b;
        pg = i_a ^ i_b;
        ii = '0;
        jj = '0;
        // Up-sweep: targets of one level never feed another target of the same level,
        // so the group terms can be updated in place.
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    ii     = 5'(i);
                    jj     = 5'(i - (1 << l));
                    g[ii]  = g[ii] | (pg[ii] & g[jj]);
                    pg[ii] = pg[ii] & pg[jj];
                end
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (2 << l))) begin
                    ii    = 5'(i);
                    jj    = 5'(i - (1 << l));
                    g[ii] = g[ii] | (pg[ii] & g[jj]);
                end
            end
        end
        o_sum = (i_a ^ i_b) ^ {g[30:0], 1'b0};
    end

endmodule

// File: rtl/haar_idwt_pair_core.sv
// Combinational inverse Haar butterfly: x0 = K*(cA+cD), x1 = K*(cA-cD), fixed-point truncated.
module haar_idwt_pair_core
    import haar_idwt_serializer_pkg::*;
(
    input  logic [COEF_W-1:0] i_ca,
    input  logic [COEF_W-1:0] i_cd,
    output logic [COEF_W-1:0] o_x0,
    output logic [COEF_W-1:0] o_x1
);

    logic [31:0] w_ca;
    logic [31:0] w_cd;
    logic [31:0] w_cd_neg;
    logic [31:0] w_s;
    logic [31:0] w_d;
    logic [31:0] w_m0;
    logic [31:0] w_m1;
    logic        w_unused;

    assign w_ca = {{(32 - COEF_W){1'b0}}, i_ca};
    assign w_cd = {{(32 - COEF_W){1'b0}}, i_cd};

    brent_kung_adder_32bit u_neg (.i_a(~w_cd), .i_b(32'd1), .o_sum(w_cd_neg));
    brent_kung_adder_32bit u_sum (.i_a(w_ca), .i_b(w_cd), .o_sum(w_s));
    brent_kung_adder_32bit u_dif (.i_a(w_ca), .i_b(w_cd_neg), .o_sum(w_d));

    mult_by_181 u_m0 (.i_a(w_s), .o_p(w_m0));
    mult_by_181 u_m1 (.i_a(w_d), .o_p(w_m1));

    assign o_x0 = w_m0[HAAR_FRAC +: COEF_W];
    assign o_x1 = w_m1[HAAR_FRAC +: COEF_W];

    assign w_unused = ^{w_m0[31:HAAR_FRAC+COEF_W], w_m0[HAAR_FRAC-1:0],
                        w_m1[31:HAAR_FRAC+COEF_W], w_m1[HAAR_FRAC-1:0]};

endmodule

// File: rtl/mult_by_181.sv
// Constant multiply by 181 (128+32+16+4+1), modulo 2^32.
module mult_by_181 (
    input  logic [31:0] i_a,
    output logic [31:0] o_p
);

    assign o_p = (i_a << 7) + (i_a << 5) + (i_a << 4) + (i_a << 2) + i_a;

endmodule

// File: rtl/haar_idwt_serializer.sv
// Inverse Haar stage: captures a coefficient frame, reconstructs one sample pair at a time
// and streams the N samples out with valid/ready backpressure.
module haar_idwt_serializer
    import haar_idwt_serializer_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_valid,
    output logic                       coef_ready,
    input  logic [COEF_W*(N/2)-1:0]    cA_in,
    input  logic [COEF_W*(N/2)-1:0]    cD_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COEF_W-1:0]          out_data,
    output logic                       out_last,
    output logic                       busy
);

    localparam int unsigned NPairs = N / 2;
    localparam int unsigned KW     = (NPairs > 1) ? $clog2(NPairs) : 1;
    localparam logic [KW-1:0] KLast = KW'(NPairs - 1);

    state_t                     r_state, w_state_nxt;
    logic [KW-1:0]              r_k, w_k_nxt;
    logic [COEF_W*NPairs-1:0]   r_ca, w_ca_nxt;
    logic [COEF_W*NPairs-1:0]   r_cd, w_cd_nxt;
    logic [COEF_W-1:0]          r_x1, w_x1_nxt;
    logic                       r_out_valid, w_out_valid_nxt;
    logic [COEF_W-1:0]          r_out_data, w_out_data_nxt;
    logic                       r_out_last, w_out_last_nxt;
    logic [COEF_W-1:0]          w_ca_k;
    logic [COEF_W-1:0]          w_cd_k;
    logic [COEF_W-1:0]          w_x0;
    logic [COEF_W-1:0]          w_x1;

    assign w_ca_k = r_ca[r_k * COEF_W +: COEF_W];
    assign w_cd_k = r_cd[r_k * COEF_W +: COEF_W];

    haar_idwt_pair_core u_core (
        .i_ca (w_ca_k),
        .i_cd (w_cd_k),
        .o_x0 (w_x0),
        .o_x1 (w_x1)
    );

    // out_data doubles as the x0 result register; x1 waits in r_x1 for EMIT1.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_ca_nxt        = r_ca;
        w_cd_nxt        = r_cd;
        w_x1_nxt        = r_x1;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        unique case (r_state)
            IDLE: begin
                if (coef_valid) begin
                    w_ca_nxt    = cA_in;
                    w_cd_nxt    = cD_in;
                    w_k_nxt     = '0;
                    w_state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                w_x1_nxt        = w_x1;
                w_out_data_nxt  = w_x0;
                w_out_valid_nxt = 1'b1;
                w_out_last_nxt  = 1'b0;
                w_state_nxt     = EMIT0;
            end
            EMIT0: begin
                if (out_ready) begin
                    w_out_data_nxt = r_x1;
                    w_out_last_nxt = (r_k == KLast);
                    w_state_nxt    = EMIT1;
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_last_nxt  = 1'b0;
                    if (r_k == KLast) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_k_nxt     = r_k + KW'(1);
                        w_state_nxt = COMPUTE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_ca        <= '0;
            r_cd        <= '0;
            r_x1        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_ca        <= w_ca_nxt;
            r_cd        <= w_cd_nxt;
            r_x1        <= w_x1_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign coef_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;

endmodule

// File: tb/tb_haar_idwt_serializer.sv
// Scoreboard bench for haar_idwt_serializer: directed frames, stalls, overlap, reset abort.
module tb_haar_idwt_serializer;

    localparam int N = 8;

    typedef logic [15:0] vec4_t [4];
    typedef logic [15:0] vec8_t [8];
    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              coef_valid;
    logic              coef_ready;
    logic [16*N/2-1:0] cA_in;
    logic [16*N/2-1:0] cD_in;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic              out_last;
    logic              busy;

    haar_idwt_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .cA_in      (cA_in),
        .cD_in      (cD_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   n_hs = 0;
    int   n_last = 0;
    int   last_hs_edge = 0;

    // Hand-computed frames: (cA,cD) per pair and the 8 expected samples.
    vec4_t fa_ca = '{16'd181, 16'd100, 16'd256, 16'd0};
    vec4_t fa_cd = '{16'd0,   16'd20,  16'd0,   16'd1};
    vec8_t fa_x  = '{16'd127, 16'd127, 16'd84, 16'd56, 16'd181, 16'd181, 16'd0, 16'hFFFF};
    vec4_t fb_ca = '{16'd512, 16'd1000, 16'd10, 16'hFFFF};
    vec4_t fb_cd = '{16'd256, 16'd0,    16'd10, 16'hFFFF};
    vec8_t fb_x  = '{16'd543, 16'd181, 16'd707, 16'd707, 16'd14, 16'd0, 16'h69FE, 16'd0};
    vec4_t fc_ca = '{16'd1, 16'd300, 16'd2, 16'd0};
    vec4_t fc_cd = '{16'd0, 16'd44,  16'd3, 16'd2};
    vec8_t fc_x  = '{16'd0, 16'd0, 16'd243, 16'd181, 16'd3, 16'hFFFF, 16'd1, 16'hFFFE};
    vec4_t fz_c  = '{16'd0, 16'd0, 16'd0, 16'd0};
    vec8_t fz_x  = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sample: got %0h, expected no sample", out_data);
            end else begin
                e = sb.pop_front();
                check($sformatf("sample%0d_data", n_hs), {16'd0, out_data}, {16'd0, e.data});
                check($sformatf("sample%0d_last", n_hs), {31'd0, out_last}, {31'd0, e.last});
            end
            n_hs++;
            if (out_last) begin
                n_last++;
                last_hs_edge = cyc + 1;
            end
        end
    end

    task automatic present(input vec4_t ca, input vec4_t cd);
        for (int k = 0; k < 4; k++) begin
            cA_in[16*k +: 16] = ca[k];
            cD_in[16*k +: 16] = cd[k];
        end
        coef_valid = 1'b1;
    endtask

    // Returns at #1 after the accepting edge; acc is that edge's index.
    task automatic accept(input vec4_t ca, input vec4_t cd, input vec8_t ex, output int acc);
        logic r;
        exp_t e;
        acc = -1;
        present(ca, cd);
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            r = coef_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                for (int i = 0; i < 8; i++) begin
                    e.data = ex[i];
                    e.last = (i == 7);
                    sb.push_back(e);
                end
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got no acceptance, expected one within 64 cycles");
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (n_last >= target) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL frame_timeout: got %0d frame ends, expected %0d", n_last, target);
    endtask

    task automatic wait_hs(input int target);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #1;
            if (n_hs >= target) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL handshake_timeout: got %0d handshakes, expected %0d", n_hs, target);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int acc;
        int acc2;
        int base;
        rst        = 1'b1;
        coef_valid = 1'b0;
        out_ready  = 1'b1;
        cA_in      = '0;
        cD_in      = '0;

        repeat (2) @(negedge clk);
        check("rst_coef_ready", {31'd0, coef_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame A, no backpressure: latency and frame length.
        accept(fa_ca, fa_cd, fa_x, acc);
        coef_valid = 1'b0;
        check("A_busy_after_accept", {31'd0, busy}, 32'd1);
        check("A_ready_after_accept", {31'd0, coef_ready}, 32'd0);
        @(negedge clk);
        check("A_valid_edge1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("A_valid_edge2", {31'd0, out_valid}, 32'd1);
        wait_done(1);
        check("A_frame_len", 32'(last_hs_edge - acc), 32'd12);
        check("A_ready_after_end", {31'd0, coef_ready}, 32'd1);
        check("A_busy_after_end", {31'd0, busy}, 32'd0);

        // Frame B with a 5-cycle stall in EMIT0 of pair 1.
        base = n_hs;
        accept(fb_ca, fb_cd, fb_x, acc);
        coef_valid = 1'b0;
        wait_hs(base + 2);
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("B_stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("B_stall%0d_data", i), {16'd0, out_data}, 32'd707);
            check($sformatf("B_stall%0d_last", i), {31'd0, out_last}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done(2);
        check("B_frame_len", 32'(last_hs_edge - acc), 32'd17);

        // Frame A again with a mid-frame pulse of frame C buses.
        accept(fa_ca, fa_cd, fa_x, acc);
        coef_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 present(fc_ca, fc_cd);
        @(negedge clk);
        check("mid_coef_ready", {31'd0, coef_ready}, 32'd0);
        @(posedge clk);
        #1 coef_valid = 1'b0;
        wait_done(3);
        check("A2_frame_len", 32'(last_hs_edge - acc), 32'd12);

        // Back-to-back: valid held high, buses switched to C after B is taken.
        accept(fb_ca, fb_cd, fb_x, acc);
        accept(fc_ca, fc_cd, fc_x, acc2);
        coef_valid = 1'b0;
        check("b2b_accept_gap", 32'(acc2 - acc), 32'd13);
        wait_done(5);
        check("b2b_C_frame_len", 32'(last_hs_edge - acc2), 32'd12);

        // Reset during EMIT1 of pair 2 of frame C.
        base = n_hs;
        accept(fc_ca, fc_cd, fc_x, acc);
        coef_valid = 1'b0;
        wait_hs(base + 5);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_data", {16'd0, out_data}, 32'hFFFF);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out_data", {16'd0, out_data}, 32'd0);
        check("abort_out_last", {31'd0, out_last}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_coef_ready", {31'd0, coef_ready}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        accept(fa_ca, fa_cd, fa_x, acc);
        coef_valid = 1'b0;
        wait_done(6);
        check("post_rst_frame_len", 32'(last_hs_edge - acc), 32'd12);

        // All-zero frame.
        accept(fz_c, fz_c, fz_x, acc);
        coef_valid = 1'b0;
        wait_done(7);
        check("zero_frame_len", 32'(last_hs_edge - acc), 32'd12);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
